tetris_input_ctrl: RTL and testbench
====================================

Name: tetris_input_ctrl

Overview:
- Upstream stage of the tetris game core. Converts the four debounced push-button levels into single-cycle move commands on the core's 3-bit ctrl bus.
- Adds delayed auto-shift (DAS) and auto-repeat (ARR) for held buttons.
- Generates the gravity drop command from a level-dependent timer.
- Replaces the combinational level-to-ctrl mapping in the top level, so the core sees exactly one command per intended move.

Parameters:
- DAS_CYCLES, 10_000_000: cycles a button is held before auto-repeat starts (200 ms at 50 MHz).
- ARR_CYCLES, 2_500_000: cycles between repeated commands while held (50 ms).
- GRAVITY_BASE, 50_000_000: gravity period at speed 0 (1 s).
- GRAVITY_STEP, 3_000_000: period reduction per speed unit.
- GRAVITY_MIN, 5_000_000: floor on the gravity period.
- CNT_W, 26: width of all timers; must hold GRAVITY_BASE.

Ports:
- clk  in  1  50 MHz system clock (clk_50MHz domain).
- reset  in  1  synchronous, active-high reset.
- en  in  1  game running; 0 freezes all command generation.
- btn  in  4  debounced levels: [3] rotate, [2] left, [1] down, [0] right.
- speed  in  4  game level; selects the gravity period.
- ctrl  out  3  command to the core. 0 = nop, 2 = rotate, 3 = left, 4 = right, 5 = down. Registered; each command lasts exactly one cycle.

Behaviour:
- Reset:
  - ctrl = 0.
  - FSM = IDLE, active button = none.
  - DAS/ARR counter = 0, gravity counter = 0, gravity_pending = 0.
- Active button: the highest-priority held button. Priority is rotate > left > down > right. Combinational over btn sampled at cycle N.
- FSM states: IDLE, DELAY, REPEAT, HOLD.
  - Any state → press, when the active button changes to a new non-none value (including from none):
    - ctrl = that button's code at N+1 (latency 1).
    - Counter cleared.
    - Next state is DELAY, or HOLD if the button is rotate.
  - DELAY: counter increments each cycle. At count DAS_CYCLES-1, emit the code, clear the counter, go to REPEAT.
  - REPEAT: emit the code every ARR_CYCLES cycles, i.e. when count == ARR_CYCLES-1, then clear the counter.
  - HOLD (rotate): never repeats. Rotate must be released and pressed again to issue another rotate.
  - Any state → IDLE when the active button becomes none. No output, counter cleared.
- A lower-priority button pressed while a higher one is held is ignored. Releasing the higher one makes the lower button active. This counts as a new press and emits immediately.
- Gravity:
  - Period P = max(GRAVITY_BASE - speed*GRAVITY_STEP, GRAVITY_MIN).
  - The product is computed at CNT_W+4 bits so it cannot wrap.
  - The gravity counter increments every enabled cycle. At count P-1 it clears and sets gravity_pending.
  - A speed change takes effect at the next compare. If the counter is already ≥ P-1, it expires on the next cycle.
- Output merge, evaluated each cycle:
  - A button command wins.
  - Otherwise, if gravity_pending, ctrl = 5 and gravity_pending clears.
  - Otherwise ctrl = 0.
- Any emitted down command (manual or gravity) clears the gravity counter and gravity_pending. A manual down therefore absorbs a simultaneous gravity tick; there are no double drops.
- en = 0:
  - ctrl = 0 from the next cycle.
  - FSM forced to IDLE; all counters and gravity_pending cleared.
  - A button held while en rises is treated as a new press on the first enabled cycle.
- Reset asserted mid-hold: state as at reset on the next cycle. A button held across reset release emits as a new press.

Decomposition:
- Shared package tetris_pkg:
  - ctrl code constants CTRL_NOP/ROTATE/LEFT/RIGHT/DOWN.
  - Button index constants.
  - Used by this block, the tetris core and the top level.
- One sub-module: tetris_gravity_timer (speed → period computation, counter, pending flag, clear input).
- The DAS/ARR FSM stays in the parent.

Test Plan (DAS_CYCLES=4, ARR_CYCLES=2, GRAVITY_BASE=20, GRAVITY_STEP=4, GRAVITY_MIN=6, en=1 unless stated):
- Left held from cycle 10 with speed=15 (gravity far off) → ctrl=3 at cycles 11, 15, 17, 19, …; 0 on all other cycles. Release at 20 → no further 3.
- Rotate held 30 cycles → exactly one ctrl=2, at cycle after press. Release and press again → a second ctrl=2.
- Right held, then left pressed at cycle 5 with right still held → ctrl=3 at cycle 6. Left released at 12 → ctrl=4 at 13, and DAS restarts from 13.
- No buttons, speed=0 → ctrl=5 every 20 cycles. speed=4 → period 6 (floor; 20-16=4 clamped).
- Gravity expiry coincides with a manual down press → single ctrl=5 and the gravity counter restarts. Repeat with a rotate press → ctrl=2, then ctrl=5 the next cycle.
- Reset (or en=0) asserted while down is in REPEAT → ctrl=0 the following cycle. Down still held at release → ctrl=5 one cycle after release, then the DAS delay again.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris game: ctrl bus command codes, push-button
// bit positions, input-controller FSM states and the active-button priority
// helper. Imported by the input controller, the game core and the top level.
package tetris_pkg;

    // Commands carried on the 3-bit ctrl bus into the game core
    localparam logic [2:0] CTRL_NOP    = 3'd0;
    localparam logic [2:0] CTRL_ROTATE = 3'd2;
    localparam logic [2:0] CTRL_LEFT   = 3'd3;
    localparam logic [2:0] CTRL_RIGHT  = 3'd4;
    localparam logic [2:0] CTRL_DOWN   = 3'd5;

    // Bit positions inside the 4-bit debounced button vector
    localparam int BTN_RIGHT  = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_ROTATE = 3;

    // Delayed auto-shift / auto-repeat states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HOLD   = 2'd3
    } input_state_e;

    // Highest-priority held button, expressed directly as its ctrl code
    // (CTRL_NOP when nothing is held). Priority: rotate > left > down > right.
    function automatic logic [2:0] active_code(input logic [3:0] btn);
        logic [2:0] code;
        if (btn[BTN_ROTATE]) begin
            code = CTRL_ROTATE;
        end else if (btn[BTN_LEFT]) begin
            code = CTRL_LEFT;
        end else if (btn[BTN_DOWN]) begin
            code = CTRL_DOWN;
        end else if (btn[BTN_RIGHT]) begin
            code = CTRL_RIGHT;
        end else begin
            code = CTRL_NOP;
        end
        return code;
    endfunction

endpackage

// File: rtl/tetris_gravity_timer.sv
// Gravity timer for the tetris input controller.
// Derives the drop period from the game speed, counts enabled cycles and
// raises a pending flag each time the period expires.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   en       in   game running; 0 clears counter and pending flag
//   speed    in   [3:0] game level selecting the period
//   clear    in   a down command is being emitted: restart the period
//   consume  in   the pending drop is being emitted this cycle
//   pending  out  a gravity drop is waiting to be emitted
module tetris_gravity_timer
    import tetris_pkg::*;
#(
    parameter int GRAVITY_BASE = 50_000_000,
    parameter int GRAVITY_STEP = 3_000_000,
    parameter int GRAVITY_MIN  = 5_000_000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] speed,
    input  logic       clear,
    input  logic       consume,
    output logic       pending
);

    // Four extra bits make room for speed (max 15) times the step.
    localparam int PW = CNT_W + 4;

    logic [PW-1:0]    step_prod;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt;
    logic             expire;

    assign step_prod = PW'(speed) * PW'(GRAVITY_STEP);

    // Period = max(BASE - speed*STEP, MIN); compared before subtracting so
    // the difference can never go negative.
    always_comb begin
        period = CNT_W'(GRAVITY_MIN);
        if (step_prod + PW'(GRAVITY_MIN) >= PW'(GRAVITY_BASE)) begin
            period = CNT_W'(GRAVITY_MIN);
        end else begin
            period = CNT_W'(PW'(GRAVITY_BASE) - step_prod);
        end
    end

    // ">=" so that a speed increase past the current count expires at once.
    assign expire = (cnt >= period - CNT_W'(1));

    // Counter and pending flag; an emitted down absorbs any expiry this cycle.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else if (expire) begin
            cnt     <= '0;
            pending <= 1'b1;
        end else begin
            cnt <= cnt + CNT_W'(1);
            if (consume) begin
                pending <= 1'b0;
            end else begin
                pending <= pending;
            end
        end
    end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Tetris input controller: turns debounced button levels into one-cycle
// move commands with delayed auto-shift and auto-repeat, and merges in
// gravity drops from the gravity timer.
// Ports:
//   clk    in   50 MHz system clock
//   reset  in   synchronous active-high reset
//   en     in   game running; 0 freezes command generation
//   btn    in   [3:0] debounced levels: [3] rotate, [2] left, [1] down, [0] right
//   speed  in   [3:0] game level selecting the gravity period
//   ctrl   out  [2:0] registered one-cycle command to the core
module tetris_input_ctrl
    import tetris_pkg::*;
#(
    parameter int DAS_CYCLES   = 10_000_000,
    parameter int ARR_CYCLES   = 2_500_000,
    parameter int GRAVITY_BASE = 50_000_000,
    parameter int GRAVITY_STEP = 3_000_000,
    parameter int GRAVITY_MIN  = 5_000_000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] btn,
    input  logic [3:0] speed,
    output logic [2:0] ctrl
);

    input_state_e     state;
    logic [2:0]       held;       // ctrl code of the button being tracked
    logic [CNT_W-1:0] cnt;
    logic [2:0]       active;
    logic [2:0]       btn_cmd;
    logic [2:0]       next_ctrl;
    logic             grav_pending;
    logic             grav_clear;
    logic             grav_consume;

    assign active = active_code(btn);

    // Button command for this cycle: a fresh press emits at once, otherwise
    // the DAS/ARR counter decides.
    always_comb begin
        btn_cmd = CTRL_NOP;
        if (active == CTRL_NOP) begin
            btn_cmd = CTRL_NOP;
        end else if (active != held) begin
            btn_cmd = active;
        end else if (state == ST_DELAY && cnt == CNT_W'(DAS_CYCLES - 1)) begin
            btn_cmd = held;
        end else if (state == ST_REPEAT && cnt == CNT_W'(ARR_CYCLES - 1)) begin
            btn_cmd = held;
        end else begin
            btn_cmd = CTRL_NOP;
        end
    end

    // Button commands take precedence; a pending gravity drop waits for a
    // free cycle.
    always_comb begin
        next_ctrl = CTRL_NOP;
        if (btn_cmd != CTRL_NOP) begin
            next_ctrl = btn_cmd;
        end else if (grav_pending) begin
            next_ctrl = CTRL_DOWN;
        end else begin
            next_ctrl = CTRL_NOP;
        end
    end

    // Any manual down restarts gravity; a gravity drop only consumes pending.
    assign grav_clear   = (btn_cmd == CTRL_DOWN);
    assign grav_consume = (btn_cmd == CTRL_NOP) && grav_pending;

    tetris_gravity_timer #(
        .GRAVITY_BASE (GRAVITY_BASE),
        .GRAVITY_STEP (GRAVITY_STEP),
        .GRAVITY_MIN  (GRAVITY_MIN),
        .CNT_W        (CNT_W)
    ) u_gravity (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .speed   (speed),
        .clear   (grav_clear),
        .consume (grav_consume),
        .pending (grav_pending)
    );

    // DAS/ARR state machine and registered command output.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            state <= ST_IDLE;
            held  <= CTRL_NOP;
            cnt   <= '0;
            ctrl  <= CTRL_NOP;
        end else begin
            ctrl <= next_ctrl;
            if (active == CTRL_NOP) begin
                state <= ST_IDLE;
                held  <= CTRL_NOP;
                cnt   <= '0;
            end else if (active != held) begin
                // New press, including a lower button revealed by a release
                held  <= active;
                cnt   <= '0;
                state <= (active == CTRL_ROTATE) ? ST_HOLD : ST_DELAY;
            end else begin
                case (state)
                    ST_DELAY: begin
                        if (cnt == CNT_W'(DAS_CYCLES - 1)) begin
                            cnt   <= '0;
                            state <= ST_REPEAT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (cnt == CNT_W'(ARR_CYCLES - 1)) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        cnt <= '0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        held  <= CTRL_NOP;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Self-checking bench for tetris_input_ctrl with small timing parameters.
module tb_tetris_input_ctrl;

    localparam int DAS  = 4;
    localparam int ARR  = 2;
    localparam int GB   = 20;
    localparam int GS   = 4;
    localparam int GM   = 6;
    localparam int HMAX = 4096;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] btn;
    logic [3:0] speed;
    logic [2:0] ctrl;

    int checks;
    int errors;
    int cyc;
    int hist [0:HMAX-1];

    tetris_input_ctrl #(
        .DAS_CYCLES   (DAS),
        .ARR_CYCLES   (ARR),
        .GRAVITY_BASE (GB),
        .GRAVITY_STEP (GS),
        .GRAVITY_MIN  (GM),
        .CNT_W        (26)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .btn   (btn),
        .speed (speed),
        .ctrl  (ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks how long the active button has been held (age 0 = press cycle)
    // and an elapsed-cycle gravity count; predicts ctrl for the next cycle.
    int m_prev;
    int m_age;
    int m_gcnt;
    int m_gpend;
    int m_exp;

    function automatic int prio(input logic [3:0] b);
        if (b[3]) return 2;
        if (b[2]) return 3;
        if (b[1]) return 5;
        if (b[0]) return 4;
        return 0;
    endfunction

    initial begin
        m_prev = 0; m_age = 0; m_gcnt = 0; m_gpend = 0; m_exp = 0; cyc = 0;
    end

    always @(posedge clk) begin
        int a, cmd, p, out;
        cyc = cyc + 1;
        if (reset || !en) begin
            m_prev = 0; m_age = 0; m_gcnt = 0; m_gpend = 0; m_exp = 0;
        end else begin
            a = prio(btn);
            cmd = 0;
            if (a == 0) begin
                m_prev = 0;
            end else if (a != m_prev) begin
                cmd = a; m_prev = a; m_age = 0;
            end else begin
                m_age = m_age + 1;
                if (a != 2 && m_age >= DAS && ((m_age - DAS) % ARR) == 0) cmd = a;
            end
            p = GB - int'(speed) * GS;
            if (p < GM) p = GM;
            out = (cmd != 0) ? cmd : (m_gpend != 0 ? 5 : 0);
            if (cmd == 5) begin
                m_gcnt = 0; m_gpend = 0;
            end else begin
                if (cmd == 0 && m_gpend != 0) m_gpend = 0;
                if (m_gcnt >= p - 1) begin
                    m_gcnt = 0; m_gpend = 1;
                end else begin
                    m_gcnt = m_gcnt + 1;
                end
            end
            m_exp = out;
        end
    end

    // Compare process: every cycle after the first edge, DUT vs model.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < HMAX) begin
            hist[cyc] = int'(ctrl);
            chk("model_ctrl", int'(ctrl), m_exp);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Pulse en low so gravity restarts; returns the first enabled cycle.
    task automatic realign(output int t0);
        en = 1'b0;
        tick(2);
        en = 1'b1;
        t0 = cyc;
    endtask

    function automatic int count_code(input int lo, input int hi, input int code);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (hist[i] == code) n++;
        return n;
    endfunction

    initial begin
        int t, t2, tl, tr;
        checks = 0;
        errors = 0;
        reset = 1'b1; en = 1'b1; btn = 4'b0000; speed = 4'd15;
        tick(3);
        chk("reset_ctrl", int'(ctrl), 0);
        chk("reset_hist", hist[2], 0);
        reset = 1'b0;
        tick(2);

        // Left held 10 cycles: 3 at +1, +5, +7, +9 only
        t = cyc; btn = 4'b0100;
        tick(10);
        btn = 4'b0000;
        tick(12);
        chk("left_press",  hist[t+1], 3);
        chk("left_das",    hist[t+5], 3);
        chk("left_arr1",   hist[t+7], 3);
        chk("left_arr2",   hist[t+9], 3);
        chk("left_gaps",   count_code(t+2, t+4, 3) + (hist[t+6] == 3 ? 1 : 0)
                           + (hist[t+8] == 3 ? 1 : 0), 0);
        chk("left_release", count_code(t+10, t+21, 3), 0);

        // Rotate held 30 cycles: exactly one 2, and again after re-press
        t = cyc; btn = 4'b1000;
        tick(30);
        btn = 4'b0000;
        tick(3);
        t2 = cyc; btn = 4'b1000;
        tick(3);
        btn = 4'b0000;
        tick(2);
        chk("rot_press",  hist[t+1], 2);
        chk("rot_once",   count_code(t+1, t+32, 2), 1);
        chk("rot_again",  hist[t2+1], 2);

        // Right held, left pressed over it, left released
        t = cyc; btn = 4'b0001;
        tick(5);
        tl = cyc; btn = 4'b0101;
        tick(7);
        tr = cyc; btn = 4'b0001;
        tick(8);
        btn = 4'b0000;
        tick(3);
        chk("right_press",   hist[t+1], 4);
        chk("left_override", hist[tl+1], 3);
        chk("right_return",  hist[tr+1], 4);
        chk("right_das_gap", count_code(tr+2, tr+4, 4), 0);
        chk("right_das",     hist[tr+5], 4);

        // Gravity, speed 0: period 20
        speed = 4'd0;
        realign(t);
        tick(45);
        chk("grav0_quiet", count_code(t+1, t+20, 5), 0);
        chk("grav0_first", hist[t+21], 5);
        chk("grav0_next",  hist[t+41], 5);

        // Gravity, speed 4: clamped to period 6
        speed = 4'd4;
        realign(t);
        tick(16);
        chk("grav4_quiet", count_code(t+1, t+6, 5), 0);
        chk("grav4_first", hist[t+7], 5);
        chk("grav4_next",  hist[t+13], 5);

        // Manual down coinciding with gravity expiry: one drop, timer restarts
        speed = 4'd0;
        realign(t);
        tick(19);
        btn = 4'b0010;
        tick(1);
        btn = 4'b0000;
        tick(25);
        chk("coinc_down",    hist[t+20], 5);
        chk("coinc_nodbl",   count_code(t+21, t+40, 5), 0);
        chk("coinc_restart", hist[t+41], 5);

        // Rotate coinciding with expiry: 2 then 5
        realign(t);
        tick(19);
        btn = 4'b1000;
        tick(1);
        btn = 4'b0000;
        tick(3);
        chk("coinc_rot",  hist[t+20], 2);
        chk("coinc_grav", hist[t+21], 5);

        // Reset during down REPEAT, down held through release
        realign(t);
        btn = 4'b0010;
        tick(8);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(8);
        btn = 4'b0000;
        tick(2);
        chk("rst_rep1",  hist[t+5], 5);
        chk("rst_rep2",  hist[t+7], 5);
        chk("rst_quiet", hist[t+9] + hist[t+10], 0);
        chk("rst_press", hist[t+11], 5);
        chk("rst_das",   hist[t+15], 5);

        // Same with en low instead of reset
        realign(t);
        btn = 4'b0010;
        tick(8);
        en = 1'b0;
        tick(2);
        en = 1'b1;
        tick(8);
        btn = 4'b0000;
        tick(2);
        chk("en_quiet", hist[t+9] + hist[t+10], 0);
        chk("en_press", hist[t+11], 5);
        chk("en_das",   hist[t+15], 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
